// File: rtl/mgt_wb_splitter_pkg.sv
// Shared types and helpers for the management Wishbone splitter.
package mgt_wb_splitter_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_e;

   localparam logic [31:0] ERR_DATA_DEF = 32'hBADC_0FFE;

   // Index field width; a single slave still gets one index bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mgt_wb_splitter_if.sv
// Classic Wishbone management bus between the SoC master and the splitter.
interface mgt_wb_splitter_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [3:0]  sel_i;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic        ack_o;
   logic [31:0] dat_o;

   modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, input ack_o, dat_o);
   modport slave  (input cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, output ack_o, dat_o);
endinterface

// File: rtl/mgt_wb_splitter_decode.sv
// Combinational address decode: base match plus in-range slave index.
module mgt_wb_splitter_decode #(
   parameter int          NUM_SLAVES = 4,
   parameter int          IDX_LSB    = 16,
   parameter int          IDX_W      = 2,
   parameter logic [31:0] BASE       = 32'h3000
) (
   input  logic [31-IDX_LSB:0]   i_adr_hi,
   output logic                  o_hit,
   output logic [IDX_W-1:0]      o_idx,
   output logic [NUM_SLAVES-1:0] o_onehot
);
   localparam int HI_W = 32 - IDX_LSB;

   logic w_base_ok;

   // BASE is adr[31:IDX_LSB] of slave 0; the index bits sit in its low IDX_W bits.
   assign w_base_ok = (i_adr_hi[HI_W-1:IDX_W] == BASE[HI_W-1:IDX_W]);
   assign o_idx     = i_adr_hi[IDX_W-1:0];
   assign o_hit     = w_base_ok && (32'(o_idx) < NUM_SLAVES);

   for (genvar n = 0; n < NUM_SLAVES; n++) begin : g_oh
      assign o_onehot[n] = o_hit && (o_idx == IDX_W'(n));
   end
endmodule

// File: rtl/mgt_wb_splitter.sv
// Management Wishbone splitter: registered decode, per-transaction timeout, error ack.
module mgt_wb_splitter
   import mgt_wb_splitter_pkg::*;
#(
   parameter int          NUM_SLAVES = 4,
   parameter int          IDX_LSB    = 16,
   parameter logic [31:0] BASE       = 32'h3000,
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
   input  logic                     mgt_wb_clk_i,
   input  logic                     mgt_wb_rst_n_i,
   mgt_wb_splitter_if.slave         mgt_wb,
   output logic [NUM_SLAVES-1:0]    s_cyc_o,
   output logic [NUM_SLAVES-1:0]    s_stb_o,
   output logic                     s_we_o,
   output logic [3:0]               s_sel_o,
   output logic [31:0]              s_adr_o,
   output logic [31:0]              s_dat_o,
   input  logic [NUM_SLAVES-1:0]    s_ack_i,
   input  logic [32*NUM_SLAVES-1:0] s_dat_i,
   output logic                     err_pulse_o,
   output logic [31:0]              err_adr_o
);
   localparam int IDX_W = idx_w(NUM_SLAVES);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e                r_state, w_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic [CNT_W-1:0]      r_cnt;
   logic [NUM_SLAVES-1:0] r_stb;
   logic                  r_ack, r_err;
   logic [31:0]           r_rdat, r_err_adr;

   logic                  w_req, w_hit, w_go_issue, w_go_ack, w_go_err;
   logic [IDX_W-1:0]      w_idx;
   logic [NUM_SLAVES-1:0] w_onehot;
   logic [31:0]           w_sdat;

   mgt_wb_splitter_decode #(
      .NUM_SLAVES(NUM_SLAVES), .IDX_LSB(IDX_LSB), .IDX_W(IDX_W), .BASE(BASE)
   ) u_dec (
      .i_adr_hi (mgt_wb.adr_i[31:IDX_LSB]),
      .o_hit    (w_hit),
      .o_idx    (w_idx),
      .o_onehot (w_onehot)
   );

   assign w_req  = mgt_wb.cyc_i & mgt_wb.stb_i;
   assign w_sdat = s_dat_i[{r_idx, 5'b0} +: 32];

   always_comb begin
      w_nxt      = r_state;
      w_go_issue = 1'b0;
      w_go_ack   = 1'b0;
      w_go_err   = 1'b0;
      case (r_state)
         ST_IDLE: if (w_req) begin
            if (w_hit) begin w_nxt = ST_ISSUE; w_go_issue = 1'b1; end
            else       begin w_nxt = ST_RESP;  w_go_err   = 1'b1; end
         end
         // Abort beats ack; ack beats timeout in the same cycle.
         ST_ISSUE: begin
            if (!mgt_wb.cyc_i)                  w_nxt = ST_IDLE;
            else if (s_ack_i[r_idx])            begin w_nxt = ST_RESP; w_go_ack = 1'b1; end
            else if (r_cnt == CNT_W'(TIMEOUT))  begin w_nxt = ST_RESP; w_go_err = 1'b1; end
         end
         ST_RESP: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge mgt_wb_clk_i or negedge mgt_wb_rst_n_i) begin
      if (!mgt_wb_rst_n_i) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_stb     <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_rdat    <= '0;
         r_err_adr <= '0;
         s_we_o    <= 1'b0;
         s_sel_o   <= '0;
         s_adr_o   <= '0;
         s_dat_o   <= '0;
      end else begin
         r_state <= w_nxt;
         r_ack   <= (w_nxt == ST_RESP);
         r_err   <= w_go_err;
         if (r_state == ST_IDLE && w_req) begin
            s_we_o  <= mgt_wb.we_i;
            s_sel_o <= mgt_wb.sel_i;
            s_adr_o <= mgt_wb.adr_i;
            s_dat_o <= mgt_wb.dat_i;
            r_idx   <= w_idx;
         end
         r_stb <= (w_nxt != ST_ISSUE) ? '0 : (w_go_issue ? w_onehot : r_stb);
         if (w_go_issue)              r_cnt <= '0;
         else if (r_state == ST_ISSUE) r_cnt <= r_cnt + 1'b1;
         if (w_go_ack) r_rdat <= w_sdat;
         if (w_go_err) begin
            r_rdat    <= ERR_DATA;
            // A decode miss has not latched the address yet.
            r_err_adr <= (r_state == ST_IDLE) ? mgt_wb.adr_i : s_adr_o;
         end
      end
   end

   assign s_cyc_o      = r_stb;
   assign s_stb_o      = r_stb;
   assign mgt_wb.ack_o = r_ack;
   assign mgt_wb.dat_o = r_rdat;
   assign err_pulse_o  = r_err;
   assign err_adr_o    = r_err_adr;
endmodule

// File: tb/tb_mgt_wb_splitter.sv
// Randomized bench for mgt_wb_splitter against a per-transaction timing model.
module tb_mgt_wb_splitter;
   localparam int          NS  = 4;
   localparam int          TO  = 8;
   localparam logic [31:0] ERR = 32'hBADC_0FFE;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NS-1:0]   s_cyc, s_stb, s_ack;
   logic            s_we, err_pulse;
   logic [3:0]      s_sel;
   logic [31:0]     s_adr, s_dat, err_adr;
   logic [32*NS-1:0] s_dat_i;

   int errors = 0;
   int checks = 0;
   logic [31:0] last_err = '0;

   mgt_wb_splitter_if bus ();

   mgt_wb_splitter #(.NUM_SLAVES(NS), .IDX_LSB(16), .BASE(32'h3000), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .mgt_wb_clk_i (clk), .mgt_wb_rst_n_i (rst_n), .mgt_wb (bus.slave),
      .s_cyc_o (s_cyc), .s_stb_o (s_stb), .s_we_o (s_we), .s_sel_o (s_sel),
      .s_adr_o (s_adr), .s_dat_o (s_dat), .s_ack_i (s_ack), .s_dat_i (s_dat_i),
      .err_pulse_o (err_pulse), .err_adr_o (err_adr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus();
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      bus.sel_i = '0; bus.adr_i = '0; bus.dat_i = '0;
      s_ack = '0; s_dat_i = '0;
   endtask

   // wt: slave wait states (ack in cycle wt+1); abort_at>0: master drops cyc in that cycle.
   task automatic txn(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                      input logic [31:0] wdat, input int wt, input logic [31:0] rdat,
                      input int abort_at);
      logic [31:0] u;
      bit hit, is_err;
      int idx, ack_c, last_stb, n;
      logic [NS-1:0] oh;
      u   = adr >> 16;
      hit = (u >= 32'h3000) && (u < 32'h3000 + NS);
      idx = hit ? int'(u - 32'h3000) : 0;
      oh  = hit ? NS'(1 << idx) : '0;
      if (!hit)             begin ack_c = 1;      last_stb = 0;        is_err = 1; end
      else if (abort_at > 0) begin ack_c = 0;     last_stb = abort_at; is_err = 0; end
      else if (wt <= TO)    begin ack_c = wt + 2; last_stb = wt + 1;   is_err = 0; end
      else                  begin ack_c = TO + 2; last_stb = TO + 1;   is_err = 1; end
      n = ((ack_c > 0) ? ack_c : last_stb) + 2;
      @(posedge clk); #1;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
      bus.sel_i = sel; bus.adr_i = adr; bus.dat_i = wdat;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         if ((abort_at > 0 && c == abort_at) || (ack_c > 0 && c == ack_c + 1)) begin
            bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
         end
         for (int s = 0; s < NS; s++) s_dat_i[32*s +: 32] = $urandom;
         if (hit) s_dat_i[32*idx +: 32] = rdat;
         s_ack = NS'($urandom_range(0, (1 << NS) - 1)) & ~oh;
         if (hit && abort_at == 0 && c == wt + 1) s_ack = s_ack | oh;
         @(negedge clk);
         chk("stb", s_stb, (c <= last_stb) ? oh : '0);
         chk("cyc", s_cyc, (c <= last_stb) ? oh : '0);
         chk("ack", bus.ack_o, c == ack_c);
         chk("err", err_pulse, (c == ack_c) && is_err);
         if (c == 1 && hit) chk("req", {s_we, s_sel, s_adr, s_dat}, {we, sel, adr, wdat});
         if (c == ack_c) begin
            if (is_err) last_err = adr;
            if (is_err || !we) chk("dat", bus.dat_o, is_err ? ERR : rdat);
            chk("eadr", err_adr, last_err);
         end
      end
      idle_bus();
   endtask

   initial begin
      logic [31:0] a;
      int wt;
      idle_bus();
      #12;
      chk("rst", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat, bus.ack_o, bus.dat_o, err_pulse, err_adr}, '0);
      @(posedge clk); #1 rst_n = 1'b1;

      txn(32'h3002_0010, 1'b0, 4'hF, 32'h0, 0, 32'h1234_5678, 0);
      txn(32'h3000_0040, 1'b1, 4'b0011, 32'hCAFE_F00D, 5, 32'h0, 0);
      txn(32'h3004_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, 0);
      txn(32'h2000_0000, 1'b1, 4'hF, 32'h1111_2222, 0, 32'h0, 0);
      txn(32'h3001_0008, 1'b0, 4'hF, 32'h0, 100, 32'h0, 0);
      txn(32'h3001_000C, 1'b0, 4'hF, 32'h0, TO, 32'h5A5A_A5A5, 0);
      txn(32'h3003_0000, 1'b0, 4'hF, 32'h0, 100, 32'h0, 3);
      txn(32'h3003_0004, 1'b0, 4'hF, 32'h0, 1, 32'h7777_0001, 0);

      // Async reset while a transaction is outstanding.
      @(posedge clk); #1;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.sel_i = 4'hF;
      bus.adr_i = 32'h3003_0020; bus.dat_i = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #2 chk("pre_rst_stb", s_stb, 4'b1000);
      rst_n = 1'b0;
      #1 chk("rst_async", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat, bus.ack_o, bus.dat_o, err_pulse, err_adr}, '0);
      idle_bus();
      last_err = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 2, 32'h0BAD_F00D, 0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0:       a = $urandom;
            1:       a = {16'h3004 + 16'($urandom_range(0, 3)), 16'($urandom)};
            default: a = {16'h3000 + 16'($urandom_range(0, NS - 1)), 16'($urandom)};
         endcase
         wt = $urandom_range(0, TO + 3);
         txn(a, 1'($urandom), 4'($urandom), $urandom, wt, $urandom,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, TO)) : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
